// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use / branch-operand stall sequencing,
// control-hazard squash and saturating stall/flush event counters.
module hazard_control_unit #(
  parameter int LOAD_USE_STALLS = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             id_is_branch,
  input  logic             id_ex_mem_read,
  input  logic             id_ex_reg_write,
  input  logic [4:0]       id_ex_destination_reg,
  input  logic             branch_taken,
  input  logic             jump,
  output logic             Data_Hazard,
  output logic             Control_Hazard,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [3:0]       LU_LEN    = 4'(LOAD_USE_STALLS);
  localparam logic [3:0]       LU_BR_LEN = 4'(LOAD_USE_STALLS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t     state, state_next;
  logic [3:0] stall_cnt, stall_cnt_next;
  logic [3:0] stall_len;
  logic       dep_rs, dep_rt, dep, load_use, branch_dep, stall_req;

  assign dep_rs     = (id_ex_destination_reg != 5'd0) && (id_ex_destination_reg == if_id_rs);
  assign dep_rt     = (id_ex_destination_reg != 5'd0) && (id_ex_destination_reg == if_id_rt);
  assign dep        = dep_rs || dep_rt;
  assign load_use   = id_ex_mem_read && dep;
  assign branch_dep = id_is_branch && id_ex_reg_write && !id_ex_mem_read && dep;

  always_comb begin
    state_next     = state;
    stall_cnt_next = stall_cnt;
    stall_req      = 1'b0;
    stall_len      = 4'd1;
    case (state)
      RUN: begin
        if (load_use || branch_dep) begin
          stall_req = 1'b1;
          if (load_use)
            stall_len = id_is_branch ? LU_BR_LEN : LU_LEN;
          // A single bubble needs no sequencing: the bubble in EX clears the condition.
          if (stall_len > 4'd1) begin
            state_next     = STALL;
            stall_cnt_next = stall_len - 4'd1;
          end
        end
      end
      STALL: begin
        stall_req = 1'b1;
        if (stall_cnt == 4'd1) begin
          state_next     = RUN;
          stall_cnt_next = 4'd0;
        end else begin
          stall_cnt_next = stall_cnt - 4'd1;
        end
      end
      default: begin
        state_next     = RUN;
        stall_cnt_next = 4'd0;
      end
    endcase
  end

  // Stall always wins over a redirect so a branch never resolves on stale operands.
  assign Data_Hazard    = reset || !stall_req;
  assign Control_Hazard = !reset && (branch_taken || jump) && Data_Hazard;
  assign pc_write       = Data_Hazard;
  assign if_id_write    = Data_Hazard;
  assign if_id_flush    = Control_Hazard;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      stall_cnt   <= 4'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state     <= state_next;
      stall_cnt <= stall_cnt_next;
      if (!Data_Hazard && stall_count != CNT_MAX)
        stall_count <= stall_count + 1'b1;
      if (if_id_flush && flush_count != CNT_MAX)
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: two instances (default and
// LOAD_USE_STALLS=4/CNT_W=4) driven identically and checked against a bubble-count model.
module tb_hazard_control_unit;

  typedef struct packed {
    logic        dh;
    logic        ch;
    logic        fl;
    logic        pcw;
    logic        ifw;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] if_id_rs = '0, if_id_rt = '0, id_ex_destination_reg = '0;
  logic       id_is_branch = 1'b0, id_ex_mem_read = 1'b0, id_ex_reg_write = 1'b0;
  logic       branch_taken = 1'b0, jump = 1'b0;

  logic        dh_a, ch_a, pcw_a, ifw_a, fl_a;
  logic [15:0] sc_a, fc_a;
  logic        dh_b, ch_b, pcw_b, ifw_b, fl_b;
  logic [3:0]  sc_b, fc_b;

  exp_t q_a[$];
  exp_t q_b[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: bubbles still owed after this cycle, plus event totals.
  int lus[2]  = '{1, 4};
  int cmax[2] = '{65535, 15};
  int rem[2]  = '{0, 0};
  int scnt[2] = '{0, 0};
  int fcnt[2] = '{0, 0};

  hazard_control_unit dut_a (
    .clk(clk), .reset(reset), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_is_branch(id_is_branch), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_destination_reg(id_ex_destination_reg),
    .branch_taken(branch_taken), .jump(jump),
    .Data_Hazard(dh_a), .Control_Hazard(ch_a), .pc_write(pcw_a),
    .if_id_write(ifw_a), .if_id_flush(fl_a), .stall_count(sc_a), .flush_count(fc_a)
  );

  hazard_control_unit #(.LOAD_USE_STALLS(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_is_branch(id_is_branch), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_destination_reg(id_ex_destination_reg),
    .branch_taken(branch_taken), .jump(jump),
    .Data_Hazard(dh_b), .Control_Hazard(ch_b), .pc_write(pcw_b),
    .if_id_write(ifw_b), .if_id_flush(fl_b), .stall_count(sc_b), .flush_count(fc_b)
  );

  always #5 clk = ~clk;

  task automatic model_step(input int i, output exp_t e);
    bit uses, lu, bd, stalled, redirect;
    if (reset) begin
      rem[i] = 0; scnt[i] = 0; fcnt[i] = 0;
      e = '{dh: 1'b1, ch: 1'b0, fl: 1'b0, pcw: 1'b1, ifw: 1'b1, sc: 16'd0, fc: 16'd0};
      return;
    end
    uses = (id_ex_destination_reg != 0) &&
           (id_ex_destination_reg == if_id_rs || id_ex_destination_reg == if_id_rt);
    lu = id_ex_mem_read && uses;
    bd = id_is_branch && id_ex_reg_write && !id_ex_mem_read && uses;
    stalled  = (rem[i] > 0) || lu || bd;
    redirect = !stalled && (branch_taken || jump);
    e.dh = !stalled; e.pcw = !stalled; e.ifw = !stalled;
    e.ch = redirect; e.fl = redirect;
    e.sc = 16'(scnt[i]); e.fc = 16'(fcnt[i]);
    if (rem[i] > 0) rem[i] = rem[i] - 1;
    else if (lu) rem[i] = (id_is_branch ? lus[i] + 1 : lus[i]) - 1;
    if (stalled && scnt[i] < cmax[i]) scnt[i] = scnt[i] + 1;
    if (redirect && fcnt[i] < cmax[i]) fcnt[i] = fcnt[i] + 1;
  endtask

  task automatic apply_stimulus(input bit rst, input int rs, input int rt, input bit br,
                                input bit mr, input bit rw, input int dst,
                                input bit bt, input bit jmp);
    exp_t e;
    @(negedge clk);
    reset = rst;
    if_id_rs = 5'(rs); if_id_rt = 5'(rt); id_is_branch = br;
    id_ex_mem_read = mr; id_ex_reg_write = rw; id_ex_destination_reg = 5'(dst);
    branch_taken = bt; jump = jmp;
    model_step(0, e); q_a.push_back(e);
    model_step(1, e); q_b.push_back(e);
  endtask

  task automatic check_output(input string name, input exp_t act, input exp_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t actual dh/ch/fl/pcw/ifw=%b%b%b%b%b sc=%0d fc=%0d required dh/ch/fl/pcw/ifw=%b%b%b%b%b sc=%0d fc=%0d",
               name, $time, act.dh, act.ch, act.fl, act.pcw, act.ifw, act.sc, act.fc,
               exp.dh, exp.ch, exp.fl, exp.pcw, exp.ifw, exp.sc, exp.fc);
    end
  endtask

  // Monitor: outputs are combinational, so each vector is sampled 2ns after it is driven.
  initial begin
    exp_t act;
    forever begin
      @(negedge clk);
      #2;
      if (q_a.size() > 0) begin
        act = '{dh: dh_a, ch: ch_a, fl: fl_a, pcw: pcw_a, ifw: ifw_a, sc: sc_a, fc: fc_a};
        check_output("dut_a", act, q_a.pop_front());
      end
      if (q_b.size() > 0) begin
        act = '{dh: dh_b, ch: ch_b, fl: fl_b, pcw: pcw_b, ifw: ifw_b,
                sc: {12'd0, sc_b}, fc: {12'd0, fc_b}};
        check_output("dut_b", act, q_b.pop_front());
      end
    end
  end

  initial begin
    // rst, rs, rt, br, mr, rw, dst, bt, jmp
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 8, 8, 0, 1, 1, 8, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 3, 8, 0, 1, 1, 8, 0, 0);
    repeat (5) apply_stimulus(0, 3, 4, 0, 0, 0, 8, 0, 0);
    repeat (2) apply_stimulus(0, 0, 0, 0, 1, 1, 0, 0, 0);
    repeat (4) apply_stimulus(0, 9, 2, 1, 1, 1, 9, 0, 0);
    repeat (6) apply_stimulus(0, 1, 2, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 5, 1, 1, 0, 1, 5, 0, 0);
    apply_stimulus(0, 5, 1, 1, 0, 0, 0, 1, 0);
    apply_stimulus(0, 6, 7, 1, 1, 1, 7, 1, 0);
    repeat (5) apply_stimulus(0, 6, 7, 1, 0, 0, 0, 1, 0);
    apply_stimulus(0, 1, 2, 1, 0, 0, 0, 1, 1);
    apply_stimulus(0, 1, 2, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 4, 0, 0, 1, 1, 4, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (20) apply_stimulus(0, 8, 3, 0, 1, 1, 8, 1, 0);
    repeat (4) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);

    for (int n = 0; n < 600; n++) begin
      apply_stimulus(($urandom_range(0, 63) == 0),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 1) == 0), int'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
    end

    @(negedge clk);
    #3;
    vectors++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain actual %0d/%0d pending required 0/0",
               q_a.size(), q_b.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
